// File: rtl/ymux_arbiter_pkg.sv
// Shared definitions for the ymux_arbiter slice: FSM encoding, requester count
// and the one-hot grant helper.
package ymux_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ymux_arbiter_mux.sv
// SIZE-bit 2:1 mux stage and the 4:1 tree built from three of them.
module yMux2 #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    input  logic            i_c,
    output logic [SIZE-1:0] o_z
);
    assign o_z = i_c ? i_b : i_a;
endmodule

module yMux4to1 #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] i_a0,
    input  logic [SIZE-1:0] i_a1,
    input  logic [SIZE-1:0] i_a2,
    input  logic [SIZE-1:0] i_a3,
    input  logic [1:0]      i_sel,
    output logic [SIZE-1:0] o_z
);
    logic [SIZE-1:0] w_lo;
    logic [SIZE-1:0] w_hi;

    yMux2 #(.SIZE(SIZE)) u_lo  (.i_a(i_a0), .i_b(i_a1), .i_c(i_sel[0]), .o_z(w_lo));
    yMux2 #(.SIZE(SIZE)) u_hi  (.i_a(i_a2), .i_b(i_a3), .i_c(i_sel[0]), .o_z(w_hi));
    yMux2 #(.SIZE(SIZE)) u_out (.i_a(w_lo), .i_b(w_hi), .i_c(i_sel[1]), .o_z(o_z));
endmodule

// File: rtl/ymux_arbiter_rrpick.sv
// Rotate-priority encoder: first requester at or after i_ptr (mod 4) with req high.
module yRRPick
    import ymux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic               o_found,
    output logic [1:0]         o_idx
);
    // Walk from lowest to highest priority so the nearest hit to i_ptr wins last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[i_ptr + 2'(k)]) begin
                o_found = 1'b1;
                o_idx   = i_ptr + 2'(k);
            end
        end
    end
endmodule

// File: rtl/ymux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux datapath among four requesters,
// with multi-beat grants capped at HOLD_MAX beats.
module ymux_arbiter
    import ymux_arbiter_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [SIZE-1:0]    d0,
    input  logic [SIZE-1:0]    d1,
    input  logic [SIZE-1:0]    d2,
    input  logic [SIZE-1:0]    d3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic [SIZE-1:0]    z,
    output logic               z_valid,
    output logic               busy
);
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t              r_state,   w_state_nxt;
    logic [1:0]          r_ptr,     w_ptr_nxt;
    logic [3:0]          r_cnt,     w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_gnt,     w_gnt_nxt;
    logic [1:0]          r_sel,     w_sel_nxt;
    logic [SIZE-1:0]     r_z,       w_z_nxt;
    logic                r_z_valid, w_z_valid_nxt;

    logic                w_idle_found;
    logic [1:0]          w_idle_idx;
    logic                w_ho_found;
    logic [1:0]          w_ho_idx;
    logic [1:0]          w_ho_ptr;
    logic [SIZE-1:0]     w_mux_z;
    logic                w_accept;
    logic                w_last;
    logic [3:0]          w_cnt_inc;
    logic                w_end;

    // Handoff searches from one past the current holder so it becomes lowest priority.
    assign w_ho_ptr  = r_sel + 2'd1;
    assign w_accept  = req[r_sel];
    assign w_last    = last[r_sel];
    assign w_cnt_inc = r_cnt + 4'd1;

    yRRPick u_pick_idle (.i_req(req), .i_ptr(r_ptr),    .o_found(w_idle_found), .o_idx(w_idle_idx));
    yRRPick u_pick_ho   (.i_req(req), .i_ptr(w_ho_ptr), .o_found(w_ho_found),   .o_idx(w_ho_idx));

    yMux4to1 #(.SIZE(SIZE)) u_mux (
        .i_a0(d0), .i_a1(d1), .i_a2(d2), .i_a3(d3),
        .i_sel(r_sel),
        .o_z(w_mux_z)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_sel_nxt     = r_sel;
        w_z_nxt       = r_z;
        w_z_valid_nxt = 1'b0;
        w_end         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_idle_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = onehot4(w_idle_idx);
                    w_sel_nxt   = w_idle_idx;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    w_z_nxt       = w_mux_z;
                    w_z_valid_nxt = 1'b1;
                    w_cnt_nxt     = w_cnt_inc;
                    w_end         = w_last || (w_cnt_inc == HOLD_LIM);
                end else begin
                    w_end = 1'b1;
                end
                // Regrant in the same edge when anyone is waiting: no idle bubble.
                if (w_end) begin
                    w_ptr_nxt = w_ho_ptr;
                    w_cnt_nxt = 4'd0;
                    if (w_ho_found) begin
                        w_gnt_nxt = onehot4(w_ho_idx);
                        w_sel_nxt = w_ho_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_cnt     <= 4'd0;
            r_gnt     <= '0;
            r_sel     <= 2'd0;
            r_z       <= '0;
            r_z_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_sel     <= w_sel_nxt;
            r_z       <= w_z_nxt;
            r_z_valid <= w_z_valid_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign z       = r_z;
    assign z_valid = r_z_valid;
    assign busy    = (r_state == ST_GRANT);

endmodule

// File: tb/tb_ymux_arbiter.sv
// Bench for ymux_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic, all compared against a behavioural arbitration model.
module tb_ymux_arbiter;
    localparam int SIZE     = 32;
    localparam int HOLD_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [3:0]      last;
    logic [SIZE-1:0] d0, d1, d2, d3;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic [SIZE-1:0] z;
    logic            z_valid;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ymux_arbiter #(.SIZE(SIZE), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt), .sel(sel), .z(z), .z_valid(z_valid), .busy(busy)
    );

    // Model: who holds the grant (-1 = nobody), rotating pointer, beats so far.
    int              m_holder;
    int              m_ptr;
    int              m_cnt;
    logic [SIZE-1:0] m_z;
    logic            m_zv;
    logic [1:0]      m_sel;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        return (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
    endfunction

    task automatic model_step();
        logic [SIZE-1:0] dv [4];
        int  g;
        int  w;
        bit  done;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        if (rst) begin
            m_holder = -1; m_ptr = 0; m_cnt = 0; m_z = '0; m_zv = 1'b0; m_sel = 2'd0;
        end else if (m_holder < 0) begin
            m_zv = 1'b0;
            w = rr_pick(req, m_ptr);
            if (w >= 0) begin
                m_holder = w; m_sel = 2'(w); m_cnt = 0;
            end
        end else begin
            g = m_holder;
            if (req[g]) begin
                m_z  = dv[g];
                m_zv = 1'b1;
                m_cnt++;
                done = last[g] || (m_cnt == HOLD_MAX);
            end else begin
                m_zv = 1'b0;
                done = 1'b1;
            end
            if (done) begin
                m_ptr = (g + 1) % 4;
                w = rr_pick(req, m_ptr);
                if (w >= 0) begin
                    m_holder = w; m_sel = 2'(w); m_cnt = 0;
                end else begin
                    m_holder = -1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("mdl_gnt", SIZE'(gnt), SIZE'(m_gnt()));
        check("mdl_busy", SIZE'(busy), SIZE'(m_holder >= 0));
        check("mdl_z", z, m_z);
        check("mdl_zv", SIZE'(z_valid), SIZE'(m_zv));
        if (m_holder >= 0) check("mdl_sel", SIZE'(sel), SIZE'(m_sel));
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                         input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [SIZE-1:0] c, input logic [SIZE-1:0] d);
        rst = r; req = rq; last = ls; d0 = a; d1 = b; d2 = c; d3 = d;
    endtask

    task automatic reset_step();
        drive(1'b1, 4'b0000, 4'b0000, '0, '0, '0, '0);
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic            rst;
        logic [3:0]      req;
        logic [3:0]      last;
        logic [SIZE-1:0] d0, d1, d2, d3;
        logic [3:0]      e_gnt;
        logic [1:0]      e_sel;
        logic [SIZE-1:0] e_z;
        logic            e_zv;
        logic            e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                                input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                input logic [SIZE-1:0] c, input logic [SIZE-1:0] d,
                                input logic [3:0] eg, input logic [1:0] es,
                                input logic [SIZE-1:0] ez, input logic ezv, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.last = ls; v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
        v.e_gnt = eg; v.e_sel = es; v.e_z = ez; v.e_zv = ezv; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        logic [SIZE-1:0] da, db, dx, dy;
        logic [3:0]      rq_prev;
        drive(1'b1, 4'b0000, 4'b0000, '0, '0, '0, '0);

        // Reset, single request, then withdrawal to IDLE.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0,                  4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 32'h12345678, 0,       4'b0100, 2, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 32'h12345678, 0,       4'b0100, 2, 32'h12345678, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h12345678, 0,       4'b0000, 2, 32'h12345678, 0, 0));
        // Round-robin rotation with every requester single-beat.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0,                  4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0001, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0010, 1, 32'hA0, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0100, 2, 32'hA1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b1000, 3, 32'hA2, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0001, 0, 32'hA3, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0010, 1, 32'hA0, 1, 1));
        // Reset mid-transfer, then the grant restarts at requester 0.
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'hA5, 0, 0, 0,             4'b0001, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'hA5, 0, 0, 0,             4'b0001, 0, 32'hA5, 1, 1));
        tbl.push_back(mk(1, 4'b0001, 4'b0000, 32'hA5, 0, 0, 0,             4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'hA5, 0, 0, 0,             4'b0001, 0, 0, 0, 1));
        // Four capped beats, sole requester regranted without a bubble.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'hA5, 0, 0, 0,         4'b0001, 0, 32'hA5, 1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
            step();
            check($sformatf("row%0d_gnt", i), SIZE'(gnt), SIZE'(tbl[i].e_gnt));
            check($sformatf("row%0d_z", i), z, tbl[i].e_z);
            check($sformatf("row%0d_zv", i), SIZE'(z_valid), SIZE'(tbl[i].e_zv));
            check($sformatf("row%0d_busy", i), SIZE'(busy), SIZE'(tbl[i].e_busy));
            if (tbl[i].e_busy || tbl[i].rst)
                check($sformatf("row%0d_sel", i), SIZE'(sel), SIZE'(tbl[i].e_sel));
        end

        // HOLD_MAX cap: requester 0 gets exactly HOLD_MAX beats, then 1 with no bubble.
        reset_step();
        da = $urandom; db = $urandom;
        drive(1'b0, 4'b0011, 4'b0000, da, db, 0, 0);
        step();
        check("cap_first_gnt", SIZE'(gnt), 32'h1);
        for (int i = 1; i <= HOLD_MAX; i++) begin
            step();
            check("cap_z", z, da);
            check("cap_zv", SIZE'(z_valid), 32'h1);
            check("cap_gnt", SIZE'(gnt), (i < HOLD_MAX) ? 32'h1 : 32'h2);
        end
        step();
        check("cap_handoff_z", z, db);
        check("cap_handoff_zv", SIZE'(z_valid), 32'h1);

        // Withdrawal by requester 3 after two beats; pointer wraps to 0.
        reset_step();
        dx = $urandom; dy = $urandom;
        drive(1'b0, 4'b1000, 4'b0000, 0, 0, 0, dx);
        step();
        check("wd_gnt", SIZE'(gnt), 32'h8);
        check("wd_sel", SIZE'(sel), 32'h3);
        step();
        check("wd_beat1_z", z, dx);
        d3 = dy;
        step();
        check("wd_beat2_z", z, dy);
        req = 4'b0000;
        d3  = ~dy;
        step();
        check("wd_zv", SIZE'(z_valid), 32'h0);
        check("wd_z_hold", z, dy);
        check("wd_busy", SIZE'(busy), 32'h0);
        check("wd_gnt_off", SIZE'(gnt), 32'h0);
        req = 4'b1111;
        step();
        check("wd_ptr_wrap", SIZE'(gnt), 32'h1);

        // Ex-holder as sole requester is regranted every beat.
        reset_step();
        drive(1'b0, 4'b0010, 4'b0010, 0, $urandom, 0, 0);
        step();
        check("sole_gnt", SIZE'(gnt), 32'h2);
        for (int i = 0; i < 4; i++) begin
            dx = $urandom;
            d1 = dx;
            step();
            check("sole_zv", SIZE'(z_valid), 32'h1);
            check("sole_z", z, dx);
            check("sole_regnt", SIZE'(gnt), 32'h2);
        end

        // Randomized traffic with sticky requests, sparse last flags and rare resets.
        reset_step();
        rq_prev = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 3) rq_prev = 4'($urandom_range(0, 15));
            req  = rq_prev;
            last = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ymux_arbiter.md
Name: ymux_arbiter

Overview:
- Round-robin controller sharing one SIZE-bit 4:1 mux datapath (a yMux4to1 tree of yMux2 stages) between four requesters.
- Grants one requester at a time and drives the mux select.
- Registers the selected word onto a shared output with a valid strobe.
- Supports multi-beat transfers, bounded by HOLD_MAX so no requester starves others.

Parameters:
- SIZE, 32, data width of each requester word and of z.
- HOLD_MAX, 4, maximum beats per grant (1..15); 4-bit beat counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request per requester; held high for every beat it wants
- last  input  4  per-requester final-beat flag; meaningful only with req
- d0  input  SIZE  requester 0 data
- d1  input  SIZE  requester 1 data
- d2  input  SIZE  requester 2 data
- d3  input  SIZE  requester 3 data
- gnt  output  4  one-hot grant, registered
- sel  output  2  mux select = index of granted requester, registered
- z  output  SIZE  registered mux output
- z_valid  output  1  z holds a beat accepted in the previous cycle
- busy  output  1  high while in GRANT

Behaviour:
- Clocking and reset: one clock domain. Synchronous, active-high reset named rst; clock named clk. All state updates on the rising edge of clk.
- Reset values: gnt=0, sel=0, z=0, z_valid=0, busy=0, ptr=0, beat count=0, state IDLE.
- rst has priority over all other events. Asserting it mid-transfer aborts the grant; no z_valid is produced for the aborted beat.
- Priority: the search starts at ptr and wraps (ptr, ptr+1, ... mod 4). The first requester found with req high wins.
- IDLE:
  - If req==0: remain in IDLE; gnt=0, busy=0.
  - Otherwise, at the edge: gnt=onehot(winner), sel=winner, count=0, busy=1, go to GRANT.
  - Latency: req sampled at edge t gives gnt visible after edge t; first beat accepted at edge t+1.
- GRANT, each edge with g=sel:
  - Beat accepted when req[g]=1: z<=d[g], z_valid<=1, count<=count+1.
  - If req[g]=0: z_valid<=0, z holds its value, and the grant ends (requester withdrew).
  - The grant also ends after an accepted beat with last[g]=1, or after an accepted beat with count+1==HOLD_MAX.
  - At grant end: ptr<=(g+1) mod 4, so the ex-holder becomes lowest priority.
  - Handoff at grant end: search req with the new ptr. The current req vector is used, so the ex-holder is eligible only if no other requester is high.
  - If a winner is found, regrant in the same edge (no idle bubble; back-to-back beats possible).
  - If no winner: gnt=0, busy=0, go to IDLE.
- z_valid is a one-cycle pulse per accepted beat. z changes only on accepted beats.
- last asserted without req is ignored. req bits of non-granted requesters never affect z.
- Simultaneous end-of-grant and new requests are resolved by the rotated pointer as above.

Decomposition:
- Shared package: state encoding constants (IDLE=0, GRANT=1) and requester count 4.
- A next-winner function/comb block takes (req, ptr) and returns (found, idx).
- One natural sub-module: yRRPick. It is a purely combinational rotate-priority encoder, instantiated twice (IDLE search and handoff search) or shared.
- The datapath instantiates the existing yMux4to1 with SIZE and feeds a SIZE-bit register for z.

Test Plan:
- Reset mid-transfer:
  - Stimulus: req=0001, last=0, d0=A5; assert rst in the second beat.
  - Required: gnt=0000, z=0, z_valid=0, busy=0 on the next edge; after release, the first grant goes to requester 0 (ptr=0).
- Single request:
  - Stimulus: req=0100, last[2]=1 on beat 1, d2=0x12345678.
  - Required: gnt=0100 and sel=2 one cycle after req; z=0x12345678 with a one-cycle z_valid; return to IDLE (busy=0).
- Round-robin rotation:
  - Stimulus: req=1111 held, last=1111.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001, back-to-back with z_valid continuously 1 after the first beat.
- HOLD_MAX cap:
  - Stimulus: req=0011, last=0, HOLD_MAX=4.
  - Required: requester 0 receives exactly 4 beats, then gnt=0010 on the next edge with no bubble.
- Withdrawal:
  - Stimulus: requester 3 granted, then req[3] dropped after 2 beats.
  - Required: z_valid=0 that cycle, z holds the last d3, ptr=0, IDLE if req=0.
- Ex-holder sole requester:
  - Stimulus: req=0010 only, last pulsed every beat.
  - Required: requester 1 is regranted immediately each grant; z_valid stays 1.
